// File: rtl/lcd_bus_receiver_pkg.sv
// lcd_bus_receiver_pkg
//   Shared definitions for the LCD bus receiver: command byte codes used on
//   the 8080-style write bus and the display window record.
//   Optional feature macro: LCD_RX_WINDOW_EN (CASET/PASET window programming).
package lcd_bus_receiver_pkg;

    localparam logic [7:0] CMD_NOP          = 8'h00;
    localparam logic [7:0] CMD_SLEEP_IN     = 8'h10;
    localparam logic [7:0] CMD_SLEEP_OUT    = 8'h11;
    localparam logic [7:0] CMD_CASET        = 8'h2A;
    localparam logic [7:0] CMD_PASET        = 8'h2B;
    localparam logic [7:0] CMD_MEMORY_WRITE = 8'h2C;

    // Inclusive pixel window, coordinates are 9 bits wide.
    typedef struct packed {
        logic [8:0] xs;
        logic [8:0] xe;
        logic [8:0] ys;
        logic [8:0] ye;
    } window_t;

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_if
//   8080-style write bus as seen between the LCD driver and this receiver.
//   Ports:
//     resx_in  bus reset, active low (asynchronous to the receiver clock)
//     wrx_in   write strobe, active low, byte taken on the rising edge
//     dcx_in   0 = command byte, 1 = data byte
//     data_in  8-bit bus data
//   Modports: master drives the bus, slave (the receiver) samples it.
interface lcd_bus_if;
    logic       resx_in;
    logic       wrx_in;
    logic       dcx_in;
    logic [7:0] data_in;

    modport master (output resx_in, wrx_in, dcx_in, data_in);
    modport slave  (input  resx_in, wrx_in, dcx_in, data_in);
endinterface

// File: rtl/lcd_bus_receiver_strobe_sync.sv
// lcd_strobe_sync
//   SYNC_W-deep synchronizers for the asynchronous bus inputs plus a rising
//   edge detector on the synchronized write strobe.
//   Ports:
//     clk_in, reset_in  system clock / synchronous active-high reset
//     resx_i, wrx_i, dcx_i, data_i   raw bus inputs
//     resx_o, dcx_o, data_o          synchronized copies
//     strobe_o                       one-cycle pulse on synchronized wrx rise
module lcd_strobe_sync #(
    parameter int SYNC_W = 2
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       resx_i,
    input  logic       wrx_i,
    input  logic       dcx_i,
    input  logic [7:0] data_i,
    output logic       resx_o,
    output logic       strobe_o,
    output logic       dcx_o,
    output logic [7:0] data_o
);

    logic [SYNC_W-1:0]      resx_q;
    logic [SYNC_W-1:0]      wrx_q;
    logic [SYNC_W-1:0]      dcx_q;
    logic [SYNC_W-1:0][7:0] data_q;
    logic                   wrx_prev_q;

    // wrx and resx reset to their idle (high) level so that leaving reset
    // never looks like a strobe edge or a bus reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            resx_q     <= '1;
            wrx_q      <= '1;
            dcx_q      <= '0;
            data_q     <= '0;
            wrx_prev_q <= 1'b1;
        end else begin
            resx_q     <= {resx_q[SYNC_W-2:0], resx_i};
            wrx_q      <= {wrx_q[SYNC_W-2:0], wrx_i};
            dcx_q      <= {dcx_q[SYNC_W-2:0], dcx_i};
            data_q     <= {data_q[SYNC_W-2:0], data_i};
            wrx_prev_q <= wrx_q[SYNC_W-1];
        end
    end

    assign resx_o   = resx_q[SYNC_W-1];
    assign strobe_o = wrx_q[SYNC_W-1] & ~wrx_prev_q;
    assign dcx_o    = dcx_q[SYNC_W-1];
    assign data_o   = data_q[SYNC_W-1];

endmodule

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver
//   Receive end of the 8080-style LCD write bus. Decodes command/data bytes,
//   assembles RGB888 pixels from R,G,B byte triplets and emits a pixel stream
//   with x/y coordinates inside the current window.
//   Optional feature macro: LCD_RX_WINDOW_EN -- CASET (0x2A) / PASET (0x2B)
//   take four parameter bytes and reprogram the window. Without it the
//   window is fixed to the full HSIZE x VSIZE frame.
//   Ports:
//     clk_in, reset_in       system clock / synchronous active-high reset
//     bus                    lcd_bus_if.slave (resx/wrx/dcx/data)
//     pixel_out, x_out, y_out, pixel_valid_out   pixel stream
//     frame_start_out / frame_done_out           MEMORY_WRITE / last pixel
//     cmd_out, cmd_valid_out                     last command byte
//     awake_out                                  SLEEP_OUT / SLEEP_IN state
//     err_out                                    protocol error pulse
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | no pixel stream open, data bytes are errors
//   PIX_R   | waiting for red byte of next pixel
//   PIX_G   | waiting for green byte (partial pixel)
//   PIX_B   | waiting for blue byte (partial pixel)
//   PARAM   | collecting CASET/PASET bytes (LCD_RX_WINDOW_EN only)
module lcd_bus_receiver
    import lcd_bus_receiver_pkg::*;
#(
    parameter int HSIZE  = 320,
    parameter int VSIZE  = 240,
    parameter int SYNC_W = 2
) (
    input  logic        clk_in,
    input  logic        reset_in,
    lcd_bus_if.slave    bus,
    output logic [23:0] pixel_out,
    output logic        pixel_valid_out,
    output logic [8:0]  x_out,
    output logic [8:0]  y_out,
    output logic        frame_start_out,
    output logic        frame_done_out,
    output logic [7:0]  cmd_out,
    output logic        cmd_valid_out,
    output logic        awake_out,
    output logic        err_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIX_R,
        S_PIX_G,
        S_PIX_B
`ifdef LCD_RX_WINDOW_EN
        , S_PARAM
`endif
    } state_t;

    localparam window_t WIN_FULL = '{xs: 9'd0, xe: 9'(HSIZE - 1),
                                     ys: 9'd0, ye: 9'(VSIZE - 1)};

    logic       resx_s;
    logic       strobe_s;
    logic       dcx_s;
    logic [7:0] data_s;

    lcd_strobe_sync #(.SYNC_W(SYNC_W)) u_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .resx_i   (bus.resx_in),
        .wrx_i    (bus.wrx_in),
        .dcx_i    (bus.dcx_in),
        .data_i   (bus.data_in),
        .resx_o   (resx_s),
        .strobe_o (strobe_s),
        .dcx_o    (dcx_s),
        .data_o   (data_s)
    );

    state_t     state_q;
    window_t    win_q;
    logic [8:0] x_q, y_q;
    logic [7:0] r_q, g_q;
    logic [23:0] pixel_q;
    logic       pixel_valid_q, frame_start_q, frame_done_q;
    logic [8:0] x_out_q, y_out_q;
    logic [7:0] cmd_q;
    logic       cmd_valid_q, awake_q, err_q;

`ifdef LCD_RX_WINDOW_EN
    logic [1:0]  param_cnt_q;
    logic [23:0] param_buf_q;
    logic        param_row_q;   // 1 = PASET (rows), 0 = CASET (columns)
    logic [15:0] p_start, p_end, p_limit;

    // Fourth byte is still on the bus when the range check is made.
    assign p_start = param_buf_q[23:8];
    assign p_end   = {param_buf_q[7:0], data_s};
    assign p_limit = param_row_q ? 16'(VSIZE) : 16'(HSIZE);
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in || !resx_s) begin
            state_q       <= S_IDLE;
            win_q         <= WIN_FULL;
            x_q           <= '0;
            y_q           <= '0;
            r_q           <= '0;
            g_q           <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            x_out_q       <= '0;
            y_out_q       <= '0;
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            awake_q       <= 1'b0;
            err_q         <= 1'b0;
`ifdef LCD_RX_WINDOW_EN
            param_cnt_q   <= '0;
            param_buf_q   <= '0;
            param_row_q   <= 1'b0;
`endif
        end else begin
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            cmd_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            if (strobe_s) begin
                if (!dcx_s) begin
                    // Command byte: always accepted, aborts any partial pixel.
                    cmd_q       <= data_s;
                    cmd_valid_q <= 1'b1;
                    if (state_q == S_PIX_G || state_q == S_PIX_B)
                        err_q <= 1'b1;
`ifdef LCD_RX_WINDOW_EN
                    if (state_q == S_PARAM)
                        err_q <= 1'b1;
`endif
                    case (data_s)
                        CMD_MEMORY_WRITE: begin
                            frame_start_q <= 1'b1;
                            x_q           <= win_q.xs;
                            y_q           <= win_q.ys;
                            state_q       <= S_PIX_R;
                        end
                        CMD_SLEEP_OUT: begin
                            awake_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                        CMD_SLEEP_IN: begin
                            awake_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                        CMD_CASET, CMD_PASET: begin
`ifdef LCD_RX_WINDOW_EN
                            param_cnt_q <= '0;
                            param_row_q <= (data_s == CMD_PASET);
                            state_q     <= S_PARAM;
`else
                            state_q     <= S_IDLE;
`endif
                        end
                        CMD_NOP: state_q <= S_IDLE;
                        default: state_q <= S_IDLE;
                    endcase
                end else begin
                    case (state_q)
                        S_IDLE: err_q <= 1'b1;
                        S_PIX_R: begin
                            r_q     <= data_s;
                            state_q <= S_PIX_G;
                        end
                        S_PIX_G: begin
                            g_q     <= data_s;
                            state_q <= S_PIX_B;
                        end
                        S_PIX_B: begin
                            pixel_q       <= {r_q, g_q, data_s};
                            pixel_valid_q <= 1'b1;
                            x_out_q       <= x_q;
                            y_out_q       <= y_q;
                            if (x_q == win_q.xe) begin
                                x_q <= win_q.xs;
                                if (y_q == win_q.ye) begin
                                    // Last pixel of the window: close the stream.
                                    frame_done_q <= 1'b1;
                                    state_q      <= S_IDLE;
                                end else begin
                                    y_q     <= y_q + 9'd1;
                                    state_q <= S_PIX_R;
                                end
                            end else begin
                                x_q     <= x_q + 9'd1;
                                state_q <= S_PIX_R;
                            end
                        end
`ifdef LCD_RX_WINDOW_EN
                        S_PARAM: begin
                            if (param_cnt_q == 2'd3) begin
                                if (p_start > p_end || p_end >= p_limit) begin
                                    err_q <= 1'b1;
                                end else if (param_row_q) begin
                                    win_q.ys <= p_start[8:0];
                                    win_q.ye <= p_end[8:0];
                                end else begin
                                    win_q.xs <= p_start[8:0];
                                    win_q.xe <= p_end[8:0];
                                end
                                state_q <= S_IDLE;
                            end else begin
                                param_buf_q <= {param_buf_q[15:0], data_s};
                                param_cnt_q <= param_cnt_q + 2'd1;
                            end
                        end
`endif
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign pixel_out       = pixel_q;
    assign pixel_valid_out = pixel_valid_q;
    assign x_out           = x_out_q;
    assign y_out           = y_out_q;
    assign frame_start_out = frame_start_q;
    assign frame_done_out  = frame_done_q;
    assign cmd_out         = cmd_q;
    assign cmd_valid_out   = cmd_valid_q;
    assign awake_out       = awake_q;
    assign err_out         = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver
//   Scoreboard bench for lcd_bus_receiver. Stimulus pushes the expected
//   output event of each bus byte; a monitor pops and compares whenever the
//   DUT pulses any of its event outputs. A reduced frame size keeps the
//   full-frame wrap test short.
module tb_lcd_bus_receiver;

    localparam int HSIZE  = 16;
    localparam int VSIZE  = 8;
    localparam int SYNC_W = 2;

    typedef struct {
        bit          pv;
        logic [23:0] px;
        logic [8:0]  x;
        logic [8:0]  y;
        bit          fd;
        bit          fs;
        bit          cv;
        logic [7:0]  cmd;
        bit          er;
        int          rise;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [23:0] pixel_out;
    logic        pixel_valid_out;
    logic [8:0]  x_out, y_out;
    logic        frame_start_out, frame_done_out;
    logic [7:0]  cmd_out;
    logic        cmd_valid_out, awake_out, err_out;

    lcd_bus_if bus ();

    lcd_bus_receiver #(.HSIZE(HSIZE), .VSIZE(VSIZE), .SYNC_W(SYNC_W)) dut (
        .clk_in          (clk),
        .reset_in        (reset),
        .bus             (bus),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .x_out           (x_out),
        .y_out           (y_out),
        .frame_start_out (frame_start_out),
        .frame_done_out  (frame_done_out),
        .cmd_out         (cmd_out),
        .cmd_valid_out   (cmd_valid_out),
        .awake_out       (awake_out),
        .err_out         (err_out)
    );

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t none_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t ev_cmd(logic [7:0] c, bit fs, bit er);
        exp_t e;
        e = '{default: 0};
        e.cv = 1; e.cmd = c; e.fs = fs; e.er = er;
        return e;
    endfunction

    function automatic exp_t ev_pix(logic [23:0] px, int x, int y, bit fd);
        exp_t e;
        e = '{default: 0};
        e.pv = 1; e.px = px; e.x = 9'(x); e.y = 9'(y); e.fd = fd;
        return e;
    endfunction

    function automatic exp_t ev_err();
        exp_t e;
        e = '{default: 0};
        e.er = 1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One bus write: wrx low 3 clk, rise, high at least 3 clk.
    task automatic send(input bit dc, input logic [7:0] b, input bit has, input exp_t e);
        exp_t t;
        t = e;
        @(negedge clk);
        bus.dcx_in  = dc;
        bus.data_in = b;
        bus.wrx_in  = 1'b0;
        repeat (3) @(negedge clk);
        bus.wrx_in = 1'b1;
        if (has) begin
            t.rise = cyc;
            sb.push_back(t);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c, input bit fs, input bit er);
        send(1'b0, c, 1'b1, ev_cmd(c, fs, er));
    endtask

    task automatic send_quiet(input logic [7:0] b);
        send(1'b1, b, 1'b0, none_e);
    endtask

    task automatic bus_reset();
        @(negedge clk);
        bus.resx_in = 1'b0;
        repeat (10) @(negedge clk);
        bus.resx_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every cycle with an event pulse consumes one scoreboard entry.
    exp_t m_e;
    bit   m_ok;
    always @(negedge clk) begin
        if (pixel_valid_out | cmd_valid_out | err_out | frame_start_out | frame_done_out) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got pv=%0b cv=%0b cmd=%0h err=%0b fs=%0b fd=%0b, required no event",
                         pixel_valid_out, cmd_valid_out, cmd_out, err_out, frame_start_out, frame_done_out);
            end else begin
                m_e = sb.pop_front();
                m_ok = (pixel_valid_out == m_e.pv) && (cmd_valid_out == m_e.cv) &&
                       (err_out == m_e.er) && (frame_start_out == m_e.fs) &&
                       (frame_done_out == m_e.fd) &&
                       (!m_e.pv || (pixel_out == m_e.px && x_out == m_e.x && y_out == m_e.y)) &&
                       (!m_e.cv || cmd_out == m_e.cmd);
                if (!m_ok) begin
                    n_fail++;
                    $display("FAIL event: got pv=%0b px=%06h x=%0d y=%0d fd=%0b fs=%0b cv=%0b cmd=%02h err=%0b; required pv=%0b px=%06h x=%0d y=%0d fd=%0b fs=%0b cv=%0b cmd=%02h err=%0b",
                             pixel_valid_out, pixel_out, x_out, y_out, frame_done_out, frame_start_out,
                             cmd_valid_out, cmd_out, err_out,
                             m_e.pv, m_e.px, m_e.x, m_e.y, m_e.fd, m_e.fs, m_e.cv, m_e.cmd, m_e.er);
                end
                n_cmp++;
                if (cyc - m_e.rise != SYNC_W + 1) begin
                    n_fail++;
                    $display("FAIL latency: got %0d clk after wrx rise, required %0d",
                             cyc - m_e.rise, SYNC_W + 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no end of test, required completion before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        none_e       = '{default: 0};
        bus.resx_in  = 1'b1;
        bus.wrx_in   = 1'b1;
        bus.dcx_in   = 1'b1;
        bus.data_in  = 8'h00;
        reset        = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_pixel_out", 32'(pixel_out), 0);
        check("rst_pixel_valid", 32'(pixel_valid_out), 0);
        check("rst_x_out", 32'(x_out), 0);
        check("rst_y_out", 32'(y_out), 0);
        check("rst_frame_start", 32'(frame_start_out), 0);
        check("rst_frame_done", 32'(frame_done_out), 0);
        check("rst_cmd_out", 32'(cmd_out), 0);
        check("rst_cmd_valid", 32'(cmd_valid_out), 0);
        check("rst_awake", 32'(awake_out), 0);
        check("rst_err", 32'(err_out), 0);

        // First pixel of a frame.
        send_cmd(8'h2C, 1, 0);
        send_quiet(8'h12);
        send_quiet(8'h34);
        send(1'b1, 8'h56, 1'b1, ev_pix(24'h123456, 0, 0, 0));
        // Command while waiting for a red byte is not a partial pixel.
        send_cmd(8'h00, 0, 0);

        // reset_in while in PIX_G.
        send_cmd(8'h2C, 1, 0);
        send_quiet(8'hAA);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_pixel_out", 32'(pixel_out), 0);
        check("midrst_cmd_out", 32'(cmd_out), 0);
        check("midrst_x_out", 32'(x_out), 0);
        send(1'b1, 8'h55, 1'b1, ev_err());

        // Abort a partial pixel with a command.
        send_cmd(8'h2C, 1, 0);
        send_quiet(8'hAA);
        send_quiet(8'hBB);
        send_cmd(8'h00, 0, 1);
        send(1'b1, 8'h77, 1'b1, ev_err());

        // Sleep control and bus reset.
        send_cmd(8'h11, 0, 0);
        check("awake_after_sleep_out", 32'(awake_out), 1);
        send_cmd(8'h10, 0, 0);
        check("awake_after_sleep_in", 32'(awake_out), 0);
        send_cmd(8'h11, 0, 0);
        check("awake_again", 32'(awake_out), 1);
        bus_reset();
        check("awake_after_resx", 32'(awake_out), 0);
        check("cmd_after_resx", 32'(cmd_out), 0);
        send(1'b1, 8'h01, 1'b1, ev_err());

        // Bus reset mid-pixel discards the partial pixel without error.
        send_cmd(8'h2C, 1, 0);
        send_quiet(8'h01);
        send_quiet(8'h02);
        bus_reset();
        send(1'b1, 8'h03, 1'b1, ev_err());

`ifndef LCD_RX_WINDOW_EN
        // CASET is an ordinary command; its parameter byte lands in IDLE.
        send_cmd(8'h2A, 0, 0);
        send(1'b1, 8'h00, 1'b1, ev_err());
`endif

        // Full frame: wrap at x = HSIZE-1, frame_done only at the last pixel.
        send_cmd(8'h2C, 1, 0);
        for (int y = 0; y < VSIZE; y++) begin
            for (int x = 0; x < HSIZE; x++) begin
                send_quiet(8'(y));
                send_quiet(8'(x));
                send(1'b1, 8'(x ^ y ^ 8'h5A), 1'b1,
                     ev_pix({8'(y), 8'(x), 8'(x ^ y ^ 8'h5A)}, x, y,
                            (x == HSIZE - 1) && (y == VSIZE - 1)));
            end
        end
        send(1'b1, 8'hEE, 1'b1, ev_err());

`ifdef LCD_RX_WINDOW_EN
        // Rejected windows: start > end, and end beyond the frame.
        send(1'b0, 8'h2A, 1'b1, ev_cmd(8'h2A, 0, 0));
        send_quiet(8'h00); send_quiet(8'h05); send_quiet(8'h00);
        send(1'b1, 8'h03, 1'b1, ev_err());
        send(1'b0, 8'h2A, 1'b1, ev_cmd(8'h2A, 0, 0));
        send_quiet(8'h00); send_quiet(8'h00); send_quiet(8'h00);
        send(1'b1, 8'h10, 1'b1, ev_err());
        // Valid window x 10..12, y 5..5.
        send(1'b0, 8'h2A, 1'b1, ev_cmd(8'h2A, 0, 0));
        send_quiet(8'h00); send_quiet(8'h0A); send_quiet(8'h00); send_quiet(8'h0C);
        send(1'b0, 8'h2B, 1'b1, ev_cmd(8'h2B, 0, 0));
        send_quiet(8'h00); send_quiet(8'h05); send_quiet(8'h00); send_quiet(8'h05);
        send_cmd(8'h2C, 1, 0);
        send_quiet(8'h01); send_quiet(8'h02);
        send(1'b1, 8'h03, 1'b1, ev_pix(24'h010203, 10, 5, 0));
        send_quiet(8'h04); send_quiet(8'h05);
        send(1'b1, 8'h06, 1'b1, ev_pix(24'h040506, 11, 5, 0));
        send_quiet(8'h07); send_quiet(8'h08);
        send(1'b1, 8'h09, 1'b1, ev_pix(24'h070809, 12, 5, 1));
`endif

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
